// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, its instruction memory and decode.
// The master modport is the fetch stage. The slave modport is the memory and decode side.
interface fetch_stage_if #(
  parameter int PC_W = 15
);
  logic            decode_stall;
  logic            interlock;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [63:0]     imem_rdata;
  logic [63:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            inst_valid;

  modport master (
    input  decode_stall, interlock, redirect_valid, redirect_pc, imem_rdata,
    output imem_en, imem_addr, inst, inst_pc, inst_valid
  );

  modport slave (
    output decode_stall, interlock, redirect_valid, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, inst, inst_pc, inst_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage. It owns the bundle PC and reads a 1-cycle-latency instruction memory.
// A 1-entry skid buffer holds a bundle while decode is held. Branch redirects flush wrong-path bundles.
module fetch_stage #(
  parameter int              PC_W       = 15,
  parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}},
  parameter logic [63:0]     NOP_BUNDLE = {3'b111, 29'b0, 3'b111, 29'b0}
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_stage_if.master bus
);

  logic            w_hold;
  logic            w_live_resp;
  logic [PC_W-1:0] r_pc;
  logic            r_resp_valid;
  logic [PC_W-1:0] r_resp_pc;
  logic            r_skid_valid;
  logic [63:0]     r_skid_data;
  logic [PC_W-1:0] r_skid_pc;

  assign w_hold      = bus.decode_stall | bus.interlock;
  // A redirect kills the response that arrives in the same cycle.
  assign w_live_resp = r_resp_valid & ~bus.redirect_valid;
  // Nothing is requested during a hold, so the single skid entry can never overflow.
  assign bus.imem_en   = rstn & ~w_hold;
  assign bus.imem_addr = bus.redirect_valid ? bus.redirect_pc : r_pc;

  // Output mux: redirect NOP, then the skid entry, then the live memory response.
  always_comb begin
    bus.inst       = NOP_BUNDLE;
    bus.inst_pc    = {PC_W{1'b0}};
    bus.inst_valid = 1'b0;
    if (bus.redirect_valid) begin
      bus.inst       = NOP_BUNDLE;
      bus.inst_pc    = {PC_W{1'b0}};
      bus.inst_valid = 1'b0;
    end else if (r_skid_valid) begin
      bus.inst       = r_skid_data;
      bus.inst_pc    = r_skid_pc;
      bus.inst_valid = 1'b1;
    end else if (w_live_resp) begin
      bus.inst       = bus.imem_rdata;
      bus.inst_pc    = r_resp_pc;
      bus.inst_valid = 1'b1;
    end else begin
      bus.inst       = NOP_BUNDLE;
      bus.inst_pc    = {PC_W{1'b0}};
      bus.inst_valid = 1'b0;
    end
  end

  // PC update. A redirect under hold parks the PC on the target so the target is fetched when hold drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_pc <= w_hold ? bus.redirect_pc : bus.redirect_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end else if (!w_hold) begin
      r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      r_pc <= r_pc;
    end
  end

  // Track the single outstanding memory request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_pc    <= {PC_W{1'b0}};
    end else begin
      r_resp_valid <= bus.imem_en;
      r_resp_pc    <= bus.imem_addr;
    end
  end

  // Skid buffer: capture on hold, drain or reload on release, drop on redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= 64'd0;
      r_skid_pc    <= {PC_W{1'b0}};
    end else if (bus.redirect_valid) begin
      r_skid_valid <= 1'b0;
    end else if (w_hold) begin
      if (w_live_resp && !r_skid_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= bus.imem_rdata;
        r_skid_pc    <= r_resp_pc;
      end else begin
        r_skid_valid <= r_skid_valid;
      end
    end else if (r_skid_valid) begin
      if (w_live_resp) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= bus.imem_rdata;
        r_skid_pc    <= r_resp_pc;
      end else begin
        r_skid_valid <= 1'b0;
      end
    end else begin
      r_skid_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of decode.
- Owns the bundle PC and drives the synchronous instruction memory (1-cycle read latency, one 64-bit two-slot bundle per address).
- Presents a 64-bit bundle to decode each cycle and honours decode_stall/interlock through a 1-entry skid buffer.
- Accepts branch redirects from downstream, flushing wrong-path bundles and replacing them with the NOP bundle.

Parameters:
- PC_W, 15: bundle address width; PC wraps modulo 2^PC_W.
- RESET_PC, 0: first bundle address fetched after reset.
- NOP_BUNDLE, {3'b111,29'b0,3'b111,29'b0}: bundle driven when no valid instruction is available.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rstn  in  1  reset, asynchronous, active-low.
- decode_stall  in  1  decode cannot accept a bundle this cycle.
- interlock  in  1  hazard hold from decode; same effect as decode_stall.
- redirect_valid  in  1  taken branch/jump resolved downstream this cycle.
- redirect_pc  in  PC_W  target bundle address.
- imem_en  out  1  read request to instruction memory.
- imem_addr  out  PC_W  read address.
- imem_rdata  in  64  data for the request issued in the previous cycle.
- inst  out  64  bundle to decode; [63:32] is the upper slot, [31:0] the lower slot.
- inst_pc  out  PC_W  address of the bundle on inst (0 when inst_valid=0).
- inst_valid  out  1  inst is a real fetched bundle, not a NOP fill.

Behaviour:
- hold = decode_stall | interlock.
- State: pc (PC_W), resp_valid, resp_pc, skid_valid, skid_data[63:0], skid_pc.

Reset (async, while rstn=0):
- pc=RESET_PC; resp_valid=0; skid_valid=0.
- imem_en=0, inst=NOP_BUNDLE, inst_valid=0, inst_pc=0.

Request (combinational):
- imem_addr = redirect_valid ? redirect_pc : pc.
- imem_en = rstn & ~hold.
- A request issued in cycle t returns on imem_rdata in cycle t+1.
- resp_valid<=imem_en; resp_pc<=imem_addr.

Live response:
- live_resp = resp_valid & ~redirect_valid.
- A redirect kills the response arriving in the same cycle.

Output mux (combinational):
- If redirect_valid: NOP_BUNDLE, inst_valid=0.
- Else if skid_valid: skid_data/skid_pc, inst_valid=1.
- Else if live_resp: imem_rdata/resp_pc, inst_valid=1.
- Else: NOP_BUNDLE, inst_valid=0.
- Decode consumes inst at the clock edge only when hold=0.

Skid buffer:
- hold & live_resp & ~skid_valid: capture imem_rdata/resp_pc into the skid, skid_valid<=1.
- hold & skid_valid: skid unchanged. No request is outstanding during hold, so there is no overflow.
- ~hold & skid_valid: skid is consumed. If live_resp is also set, the skid reloads with imem_rdata; otherwise skid_valid<=0.
- redirect_valid: skid_valid<=0, regardless of hold.

PC update (priority order):
1. redirect_valid: pc <= hold ? redirect_pc : redirect_pc+1.
2. ~hold: pc <= pc+1.
3. Otherwise pc holds.
- Arithmetic is PC_W-bit, wrapping from 2^PC_W-1 to 0.

Latency and boundaries:
- After reset deassert (cycle 0), the bundle at RESET_PC is on inst in cycle 1. Steady state is one bundle per cycle.
- Redirect in cycle t with hold=0: NOP in t, target bundle valid in t+1.
- Redirect during hold: target fetch is deferred until hold drops; no wrong-path bundle is ever emitted.
- Reset mid-operation: all state clears immediately; in-flight data is ignored.

Test Plan:
1. Reset then run, no hold; imem returns {addr,addr}. Required: inst_valid rises in cycle 1; inst_pc sequence 0,1,2,3; no gaps.
2. Hold for 3 cycles at inst_pc=5. Required: bundle 5 is held on inst through the hold via the skid; after release, sequence 5,6,7; no duplicate, no drop; imem_en=0 during hold.
3. redirect_valid with redirect_pc=0x40 while bundle 9 is returning. Required: NOP_BUNDLE and inst_valid=0 that cycle; next cycle inst_pc=0x40; bundle 9 is never emitted.
4. Redirect to 0x10 while hold=1 and skid full. Required: skid dropped; pc=0x10; no request until hold drops; first valid bundle is 0x10.
5. pc at 2^PC_W-1 (0x7FFF). Required: next inst_pc=0 (wrap).
6. rstn pulsed low mid-stream with skid full. Required: outputs are NOP/0 asynchronously; after release the sequence restarts at RESET_PC.
